ctrl_fsm: RTL and testbench

- Multi-cycle control unit that sits directly upstream of the 16-bit ALU in the RISC datapath.
- Fetches a 16-bit instruction over a req/valid handshake and decodes it into the ALU function select (FS), the register-file read/write addresses, the B-operand immediate select and the immediate value.
- Sequences the register-file write enable and the program counter through a FETCH/DECODE/EXECUTE/WRITEBACK/HALT state machine.

---
 rtl/ctrl_fsm.sv | 153 +++++++++++++++
 tb/tb_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit ahead of the ALU: fetches an instruction over a
// req/valid handshake, decodes it, and sequences rf_we and the PC.
module ctrl_fsm #(
  parameter int nBit = 16,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [nBit-1:0] imem_data,
  output logic [2:0]      FS,
  output logic [2:0]      da,
  output logic [2:0]      aa,
  output logic [2:0]      ba,
  output logic            b_sel,
  output logic [nBit-1:0] imm,
  output logic            rf_we,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [nBit-1:0] ir_q, ir_d;
  logic [2:0]      fs_q, fs_d;
  logic [2:0]      da_q, da_d;
  logic [2:0]      aa_q, aa_d;
  logic [2:0]      ba_q, ba_d;
  logic            b_sel_q, b_sel_d;
  logic [nBit-1:0] imm_q, imm_d;
  // wr_q remembers whether the decoded opcode is write-class
  logic            wr_q, wr_d;
  logic            rf_we_q, rf_we_d;

  // Next-state, handshake capture, decode and PC update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fs_d    = fs_q;
    da_d    = da_q;
    aa_d    = aa_q;
    ba_d    = ba_q;
    b_sel_d = b_sel_q;
    imm_d   = imm_q;
    wr_d    = wr_q;
    rf_we_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        da_d  = ir_q[11:9];
        aa_d  = ir_q[8:6];
        ba_d  = ir_q[5:3];
        imm_d = {{(nBit-6){ir_q[5]}}, ir_q[5:0]};
        if (ir_q[15] == 1'b0) begin
          fs_d    = ir_q[14:12];
          b_sel_d = 1'b0;
          wr_d    = 1'b1;
        end else if (ir_q[15:12] == 4'b1000) begin
          fs_d    = 3'b000;
          b_sel_d = 1'b1;
          wr_d    = 1'b1;
        end else if (ir_q[15:12] == 4'b1001) begin
          fs_d    = 3'b001;
          b_sel_d = 1'b1;
          wr_d    = 1'b1;
        end else begin
          fs_d    = 3'b000;
          b_sel_d = 1'b0;
          wr_d    = 1'b0;
        end
        if (ir_q[15:12] == 4'b1111) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // Registered so the pulse lines up exactly with WRITEBACK
        rf_we_d = wr_q;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath-control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      fs_q    <= 3'b000;
      da_q    <= 3'b000;
      aa_q    <= 3'b000;
      ba_q    <= 3'b000;
      b_sel_q <= 1'b0;
      imm_q   <= '0;
      wr_q    <= 1'b0;
      rf_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fs_q    <= fs_d;
      da_q    <= da_d;
      aa_q    <= aa_d;
      ba_q    <= ba_d;
      b_sel_q <= b_sel_d;
      imm_q   <= imm_d;
      wr_q    <= wr_d;
      rf_we_q <= rf_we_d;
    end
  end

  // Gating with rst keeps request and write quiet during a reset cycle
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign rf_we     = rf_we_q && !rst;
  assign halted    = (state_q == S_HALT);
  assign FS        = fs_q;
  assign da        = da_q;
  assign aa        = aa_q;
  assign ba        = ba_q;
  assign b_sel     = b_sel_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: hand-computed vector table, directed
// corner sequences, and random instructions against a transaction-level model.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [2:0]  FS, da, aa, ba;
  logic        b_sel;
  logic [15:0] imm;
  logic        rf_we;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  fs;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        bsel;
    logic [15:0] imm;
    logic        we;
    logic        halt;
  } dec_t;

  typedef struct {
    logic [15:0] instr;
    int          stall;
    dec_t        exp;
  } vec_t;

  dec_t       cur;
  logic [7:0] exp_pc;
  vec_t       vt[6];

  ctrl_fsm #(.nBit(16), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_valid(imem_valid), .imem_data(imem_data), .FS(FS), .da(da),
    .aa(aa), .ba(ba), .b_sel(b_sel), .imm(imm), .rf_we(rf_we), .halted(halted)
  );

  always #5 clk = ~clk;

  // Decode straight from the instruction-set rules
  function automatic dec_t ref_decode(input logic [15:0] w);
    dec_t d;
    logic [3:0] op;
    op     = w[15:12];
    d.da   = w[11:9];
    d.aa   = w[8:6];
    d.ba   = w[5:3];
    d.imm  = {{10{w[5]}}, w[5:0]};
    d.halt = (op == 4'hF);
    if (op < 4'd8) begin
      d.fs = op[2:0]; d.bsel = 1'b0; d.we = 1'b1;
    end else if (op == 4'd8) begin
      d.fs = 3'd0; d.bsel = 1'b1; d.we = 1'b1;
    end else if (op == 4'd9) begin
      d.fs = 3'd1; d.bsel = 1'b1; d.we = 1'b1;
    end else begin
      d.fs = 3'd0; d.bsel = 1'b0; d.we = 1'b0;
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dec(input string tag);
    if (!cur.halt) begin
      chk({tag, ".FS"}, 32'(FS), 32'(cur.fs));
      chk({tag, ".b_sel"}, 32'(b_sel), 32'(cur.bsel));
    end
    chk({tag, ".da"}, 32'(da), 32'(cur.da));
    chk({tag, ".aa"}, 32'(aa), 32'(cur.aa));
    chk({tag, ".ba"}, 32'(ba), 32'(cur.ba));
    chk({tag, ".imm"}, 32'(imm), 32'(cur.imm));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    imem_valid = 1'b0;
    tick();
    cur = '0;
    exp_pc = 8'd0;
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk_dec("rst");
    rst = 1'b0;
    #1;
    chk("post_rst.req", 32'(imem_req), 32'd1);
  endtask

  // Enters and leaves in FETCH (or stays in HALT for a halt opcode)
  task automatic run_instr(input logic [15:0] w, input int stall, input dec_t nd);
    for (int i = 0; i < stall; i++) begin
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      chk("stall.req", 32'(imem_req), 32'd1);
      chk("stall.addr", 32'(imem_addr), 32'(exp_pc));
      chk("stall.rf_we", 32'(rf_we), 32'd0);
      chk("stall.halted", 32'(halted), 32'd0);
      tick();
    end
    imem_valid = 1'b1;
    imem_data  = w;
    chk("fetch.req", 32'(imem_req), 32'd1);
    chk("fetch.addr", 32'(imem_addr), 32'(exp_pc));
    chk("fetch.rf_we", 32'(rf_we), 32'd0);
    tick();
    imem_valid = 1'($urandom);
    imem_data  = 16'($urandom);
    chk("decode.req", 32'(imem_req), 32'd0);
    chk("decode.rf_we", 32'(rf_we), 32'd0);
    chk("decode.halted", 32'(halted), 32'd0);
    chk_dec("decode_hold");
    tick();
    cur = nd;
    if (nd.halt) begin
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.req", 32'(imem_req), 32'd0);
      chk("halt.rf_we", 32'(rf_we), 32'd0);
      chk_dec("halt");
      return;
    end
    imem_valid = 1'($urandom);
    chk("exec.req", 32'(imem_req), 32'd0);
    chk("exec.rf_we", 32'(rf_we), 32'd0);
    chk("exec.addr", 32'(imem_addr), 32'(exp_pc));
    chk_dec("exec");
    tick();
    imem_valid = 1'($urandom);
    chk("wb.rf_we", 32'(rf_we), 32'(nd.we));
    chk("wb.req", 32'(imem_req), 32'd0);
    chk("wb.addr", 32'(imem_addr), 32'(exp_pc));
    chk_dec("wb");
    tick();
    exp_pc = exp_pc + 8'd1;
    imem_valid = 1'b0;
    chk("next.req", 32'(imem_req), 32'd1);
    chk("next.addr", 32'(imem_addr), 32'(exp_pc));
    chk("next.rf_we", 32'(rf_we), 32'd0);
    chk_dec("next");
  endtask

  initial begin
    logic [15:0] w;
    // fs, da, aa, ba, bsel, imm, we, halt -- worked out by hand
    vt[0] = '{16'h0250, 0, '{3'd0, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0010, 1'b1, 1'b0}};
    vt[1] = '{16'h83BF, 0, '{3'd0, 3'd1, 3'd6, 3'd7, 1'b1, 16'hFFFF, 1'b1, 1'b0}};
    vt[2] = '{16'h9185, 0, '{3'd1, 3'd0, 3'd6, 3'd0, 1'b1, 16'h0005, 1'b1, 1'b0}};
    vt[3] = '{16'h3E3F, 5, '{3'd3, 3'd7, 3'd0, 3'd7, 1'b0, 16'hFFFF, 1'b1, 1'b0}};
    vt[4] = '{16'hA000, 1, '{3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0}};
    vt[5] = '{16'hC1C0, 2, '{3'd0, 3'd0, 3'd7, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0}};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_instr(vt[i].instr, vt[i].stall, vt[i].exp);
    end
    chk("table.pc", 32'(imem_addr), 32'd6);

    // HALT after two ALU ops: sticky, PC frozen, only rst exits
    do_reset();
    run_instr(16'h0250, 0, vt[0].exp);
    run_instr(16'h83BF, 0, vt[1].exp);
    run_instr(16'hF000, 0, '{3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1});
    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'($urandom);
      imem_data  = 16'($urandom);
      chk("halt_hold.halted", 32'(halted), 32'd1);
      chk("halt_hold.addr", 32'(imem_addr), 32'd2);
      chk("halt_hold.req", 32'(imem_req), 32'd0);
      chk("halt_hold.rf_we", 32'(rf_we), 32'd0);
      tick();
    end
    do_reset();
    chk("halt_exit.halted", 32'(halted), 32'd0);

    // Reset asserted during EXECUTE abandons the write
    imem_valid = 1'b1;
    imem_data  = 16'h0250;
    tick();
    imem_valid = 1'b0;
    tick();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk("abort.rf_we", 32'(rf_we), 32'd0);
      chk("abort.req", 32'(imem_req), 32'd1);
      chk("abort.addr", 32'(imem_addr), 32'd0);
      tick();
    end

    // Random programme long enough to wrap the PC; NOP forced at PC 255
    do_reset();
    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h2;
      if (exp_pc == 8'd255) w = 16'hA000;
      run_instr(w, int'($urandom_range(0, 2)), ref_decode(w));
    end
    chk("random.pc", 32'(imem_addr), 32'd44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
